// File: rtl/iir_response_monitor_if.sv
// Bus between a stimulus/consumer block and iir_response_monitor.
// The master drives the control and sample stream; the slave (the monitor)
// returns the measurement status and results.
interface iir_response_monitor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] target;
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;

    logic                         busy;
    logic                         done;
    logic                         settled;
    logic                         timeout;
    logic        [CNT_W-1:0]      settle_idx;
    logic        [DATA_WIDTH:0]   peak_dev;
    logic        [CNT_W-1:0]      peak_idx;
    logic        [CNT_W-1:0]      ring_count;

    modport master (
        output start, target, sample_in, sample_valid,
        input  busy, done, settled, timeout, settle_idx, peak_dev, peak_idx, ring_count
    );

    modport slave (
        input  start, target, sample_in, sample_valid,
        output busy, done, settled, timeout, settle_idx, peak_dev, peak_idx, ring_count
    );
endinterface

// File: rtl/iir_response_monitor.sv
// iir_response_monitor
// Watches the signed output stream of an IIR filter after a start pulse and
// measures its transient response: peak deviation from a target (and where it
// occurred), the index at which a stable in-threshold run began, or a timeout
// if the stream never settles within MAX_SAMPLES valid samples.
//
// Optional build macro RESP_MON_RING_COUNT_EN: when defined, counts sign
// changes of the error (ignoring zero error) as a ringing metric; when not
// defined, ring_count is tied to zero and no sign-tracking logic exists.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset; samples ignored, waiting for start
// ST_TRACK | measurement in progress; busy=1, each valid sample evaluated
// ST_DONE  | measurement finished; results frozen until start or rst
module iir_response_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_W       = 16,
    parameter int THRESHOLD   = 10,
    parameter int STABLE_LEN  = 1000,
    parameter int MAX_SAMPLES = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    iir_response_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH:0] THR_W     = (DATA_WIDTH+1)'(THRESHOLD);
    localparam logic [CNT_W-1:0]    STABLE_LD = CNT_W'(STABLE_LEN);
    localparam logic [CNT_W-1:0]    STABLE_M1 = CNT_W'(STABLE_LEN - 1);
    localparam logic [CNT_W-1:0]    IDX_LAST  = CNT_W'(MAX_SAMPLES - 1);

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] target_q;
    logic        [CNT_W-1:0]      idx_q;
    // Samples still needed to complete the current stable run; reloaded on
    // any out-of-threshold sample, terminal count 1 means this sample settles.
    logic        [CNT_W-1:0]      stable_left_q;

    logic                         busy_q;
    logic                         done_q;
    logic                         settled_q;
    logic                         timeout_q;
    logic        [CNT_W-1:0]      settle_idx_q;
    logic        [DATA_WIDTH:0]   peak_dev_q;
    logic        [CNT_W-1:0]      peak_idx_q;

    // One extra bit so the difference of two full-range signed values and its
    // magnitude never overflow.
    logic        [DATA_WIDTH:0]   err;
    logic        [DATA_WIDTH:0]   mag;
    logic                         in_band;
    logic                         new_peak;
    logic                         settle_hit;
    logic                         sample_act;

    assign err        = {mon.sample_in[DATA_WIDTH-1], mon.sample_in}
                      - {target_q[DATA_WIDTH-1], target_q};
    assign mag        = err[DATA_WIDTH] ? (~err + 1'b1) : err;
    assign in_band    = (mag < THR_W);
    assign new_peak   = (mag > peak_dev_q);
    assign settle_hit = in_band && (stable_left_q == CNT_W'(1));
    // start wins over a coincident sample, so the start-cycle sample is dropped.
    assign sample_act = (state == ST_TRACK) && mon.sample_valid && !mon.start;

    // Measurement FSM with all result registers; start re-arms from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            target_q      <= '0;
            idx_q         <= '0;
            stable_left_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            settled_q     <= 1'b0;
            timeout_q     <= 1'b0;
            settle_idx_q  <= '0;
            peak_dev_q    <= '0;
            peak_idx_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (mon.start) begin
                state         <= ST_TRACK;
                target_q      <= mon.target;
                idx_q         <= '0;
                stable_left_q <= STABLE_LD;
                busy_q        <= 1'b1;
                settled_q     <= 1'b0;
                timeout_q     <= 1'b0;
                settle_idx_q  <= '0;
                peak_dev_q    <= '0;
                peak_idx_q    <= '0;
            end else if (sample_act) begin
                idx_q <= idx_q + 1'b1;
                if (new_peak) begin
                    peak_dev_q <= mag;
                    peak_idx_q <= idx_q;
                end
                if (in_band) begin
                    stable_left_q <= stable_left_q - 1'b1;
                end else begin
                    stable_left_q <= STABLE_LD;
                end
                if (settle_hit) begin
                    settled_q    <= 1'b1;
                    settle_idx_q <= idx_q - STABLE_M1;
                    state        <= ST_DONE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end else if (idx_q == IDX_LAST) begin
                    timeout_q <= 1'b1;
                    state     <= ST_DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

`ifdef RESP_MON_RING_COUNT_EN
    logic             sign_valid_q;
    logic             sign_q;
    logic [CNT_W-1:0] ring_q;
    logic             err_nz;

    assign err_nz = (err != '0);

    // Count polarity flips of the nonzero error; zero error leaves the stored sign alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_valid_q <= 1'b0;
            sign_q       <= 1'b0;
            ring_q       <= '0;
        end else if (mon.start) begin
            sign_valid_q <= 1'b0;
            sign_q       <= 1'b0;
            ring_q       <= '0;
        end else if (sample_act && err_nz) begin
            if (sign_valid_q && (err[DATA_WIDTH] != sign_q) && (ring_q != '1)) begin
                ring_q <= ring_q + 1'b1;
            end
            sign_q       <= err[DATA_WIDTH];
            sign_valid_q <= 1'b1;
        end
    end

    assign mon.ring_count = ring_q;
`else
    assign mon.ring_count = '0;
`endif

    assign mon.busy       = busy_q;
    assign mon.done       = done_q;
    assign mon.settled    = settled_q;
    assign mon.timeout    = timeout_q;
    assign mon.settle_idx = settle_idx_q;
    assign mon.peak_dev   = peak_dev_q;
    assign mon.peak_idx   = peak_idx_q;

endmodule

// File: tb/tb_iir_response_monitor.sv
// Testbench for iir_response_monitor: directed transients plus randomized
// runs, checked by a queue-based scoreboard fed from a sample-history model.
module tb_iir_response_monitor;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int THR  = 10;
    localparam int SLEN = 1000;
    localparam int MAXS = 10000;
    localparam longint DMIN = -(longint'(1) <<< (DW-1));
    localparam longint DMAX = (longint'(1) <<< (DW-1)) - 1;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iir_response_monitor_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    iir_response_monitor #(
        .DATA_WIDTH(DW), .CNT_W(CW), .THRESHOLD(THR),
        .STABLE_LEN(SLEN), .MAX_SAMPLES(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(bus)
    );

    typedef struct {
        bit     settled;
        bit     timeout;
        longint settle_idx;
        longint peak_dev;
        longint peak_idx;
        longint ring;
        longint done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t mon_e;

    // Reference model: keeps the whole error history of the current run.
    bit     m_active = 0;
    longint m_target = 0;
    longint m_idx = 0;
    longint m_last_bad = -1;
    longint m_errs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint clampd(input longint v);
        if (v < DMIN) return DMIN;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    task automatic model_start(input longint t);
        m_active   = 1;
        m_target   = t;
        m_idx      = 0;
        m_last_bad = -1;
        m_errs.delete();
    endtask

    task automatic model_finish(input bit settled, input longint sidx, input longint ecyc);
        exp_t   e;
        longint pk = 0;
        longint pki = 0;
        longint rc = 0;
        int     prev = 0;
        int     sg;
        foreach (m_errs[i]) begin
            if (labs(m_errs[i]) > pk) begin
                pk  = labs(m_errs[i]);
                pki = i;
            end
            if (m_errs[i] != 0) begin
                sg = (m_errs[i] > 0) ? 1 : -1;
                if (prev != 0 && sg != prev) rc++;
                prev = sg;
            end
        end
`ifndef RESP_MON_RING_COUNT_EN
        rc = 0;
`endif
        e.settled    = settled;
        e.timeout    = !settled;
        e.settle_idx = sidx;
        e.peak_dev   = pk;
        e.peak_idx   = pki;
        e.ring       = rc;
        e.done_cyc   = ecyc;
        exp_q.push_back(e);
        last_exp = e;
        m_active = 0;
    endtask

    task automatic model_sample(input longint s, input longint ecyc);
        longint e;
        if (!m_active) return;
        e = s - m_target;
        m_errs.push_back(e);
        if (labs(e) >= THR) m_last_bad = m_idx;
        if (m_idx - m_last_bad == SLEN) model_finish(1, m_last_bad + 1, ecyc);
        else if (m_idx == MAXS - 1) model_finish(0, 0, ecyc);
        m_idx++;
    endtask

    // Drive one cycle; a valid sample is handed to the model after its edge.
    task automatic send(input longint s, input bit v);
        bus.sample_in    = s[DW-1:0];
        bus.sample_valid = v;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        if (v) model_sample(s, cyc);
    endtask

    task automatic do_start(input longint t, input bit junk_valid);
        longint junk;
        junk             = longint'($urandom);
        bus.start        = 1'b1;
        bus.target       = t[DW-1:0];
        bus.sample_in    = junk[DW-1:0];
        bus.sample_valid = junk_valid;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
        model_start(t);
        chk("busy_after_start", bus.busy, 1);
        chk("peak_cleared_on_start", bus.peak_dev, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_settled"}, bus.settled, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
        chk({tag, "_settle_idx"}, bus.settle_idx, 0);
        chk({tag, "_peak_dev"}, bus.peak_dev, 0);
        chk({tag, "_peak_idx"}, bus.peak_idx, 0);
        chk({tag, "_ring"}, bus.ring_count, 0);
    endtask

    // After a run ends, extra samples must not disturb the frozen results.
    task automatic hold_check();
        repeat (5) send(longint'($urandom), 1);
        chk("hold_busy", bus.busy, 0);
        chk("hold_settled", bus.settled, last_exp.settled);
        chk("hold_timeout", bus.timeout, last_exp.timeout);
        chk("hold_settle_idx", bus.settle_idx, last_exp.settle_idx);
        chk("hold_peak_dev", bus.peak_dev, last_exp.peak_dev);
        chk("hold_peak_idx", bus.peak_idx, last_exp.peak_idx);
        chk("hold_ring", bus.ring_count, last_exp.ring);
    endtask

    task automatic random_run(input longint t, input bit extreme);
        int n = 0;
        do_start(t, 1'($urandom_range(0, 1)));
        if (extreme) send(DMIN, 1);
        repeat ($urandom_range(3, 20))
            send(clampd(t + longint'($urandom_range(0, 200000)) - 100000), 1);
        while (m_active && n < 12000) begin
            if ($urandom_range(0, 3) == 0)
                send(longint'($urandom), 0);
            else if ($urandom_range(0, 399) == 0)
                send(clampd(t + 10 + longint'($urandom_range(0, 50))), 1);
            else
                send(clampd(t + longint'($urandom_range(0, 18)) - 9), 1);
            n++;
        end
        if (m_active) begin
            n_errors++;
            $display("FAIL random_run_bound: model still active after %0d cycles, required end", n);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("busy_at_done", bus.busy, 0);
                chk("settled", bus.settled, mon_e.settled);
                chk("timeout", bus.timeout, mon_e.timeout);
                chk("settle_idx", bus.settle_idx, mon_e.settle_idx);
                chk("peak_dev", bus.peak_dev, mon_e.peak_dev);
                chk("peak_idx", bus.peak_idx, mon_e.peak_idx);
                chk("ring_count", bus.ring_count, mon_e.ring);
            end
        end
    end

    initial begin
        bus.start        = 1'b0;
        bus.target       = '0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;

        // Reset with toggling samples, then idle without start.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.sample_in    = (i % 2 == 0) ? 32'sd1234 : -32'sd777;
            bus.sample_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.sample_valid = 1'b0;
        check_zero("reset");
        for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 5000 : -5000, 1);
        check_zero("idle");

        // Clean step.
        do_start(1000, 0);
        send(0, 1); send(500, 1); send(1000, 1);
        for (int i = 0; i < 5000 && m_active; i++) send(1000, 1);
        chk("step_settled", bus.settled, 1);
        chk("step_settle_idx", bus.settle_idx, 2);
        chk("step_peak_dev", bus.peak_dev, 1000);
        chk("step_peak_idx", bus.peak_idx, 0);
        hold_check();

        // Ringing.
        do_start(0, 1);
        send(50, 1); send(-40, 1); send(30, 1); send(-20, 1); send(5, 1);
        for (int i = 0; i < 5000 && m_active; i++) send(0, 1);
        chk("ring_settle_idx", bus.settle_idx, 4);
        chk("ring_peak_dev", bus.peak_dev, 50);
        chk("ring_peak_idx", bus.peak_idx, 0);
`ifdef RESP_MON_RING_COUNT_EN
        chk("ring_count_val", bus.ring_count, 4);
`else
        chk("ring_count_val", bus.ring_count, 0);
`endif

        // Near-miss: a sample exactly at THRESHOLD breaks the run.
        do_start(0, 0);
        for (int i = 0; i < 999; i++) send(3, 1);
        send(10, 1);
        for (int i = 0; i < 5000 && m_active; i++) send(0, 1);
        chk("near_settle_idx", bus.settle_idx, 1000);
        chk("near_peak_dev", bus.peak_dev, 10);
        chk("near_peak_idx", bus.peak_idx, 999);

        // Timeout.
        do_start(0, 0);
        for (int i = 0; i < MAXS + 5 && m_active; i++) send(500, 1);
        chk("to_timeout", bus.timeout, 1);
        chk("to_settled", bus.settled, 0);
        chk("to_peak_dev", bus.peak_dev, 500);
        chk("to_peak_idx", bus.peak_idx, 0);
        hold_check();

        // Abort with a restart, then the new run settles from index 0.
        do_start(100, 0);
        for (int i = 0; i < 200; i++) send(longint'($urandom_range(0, 100000)), 1);
        do_start(-300, 1);
        for (int i = 0; i < 5000 && m_active; i++)
            send(-300 + longint'($urandom_range(0, 18)) - 9, 1);
        chk("abort_settle_idx", bus.settle_idx, 0);
        chk("abort_settled", bus.settled, 1);

        // Reset in the middle of tracking.
        do_start(0, 0);
        for (int i = 0; i < 200; i++) send(3, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_active = 0;
        check_zero("mid_rst");
        repeat (3) send(7, 1);
        chk("mid_rst_idle_busy", bus.busy, 0);

        // Randomized runs, one with full-range extremes.
        random_run(2147483647, 1);
        chk("extreme_peak_dev", bus.peak_dev, 64'd4294967295);
        for (int r = 0; r < 4; r++)
            random_run(longint'($urandom_range(0, 2000)) - 1000, 0);

        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_done: %0d results pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
